// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: operand forward selects plus stall, bubble, flush and freeze sequencing.
// Optional cycle counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_ctrl #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [REG_AW-1:0] D_Rs,
    input  logic [REG_AW-1:0] D_Rt,
    input  logic              D_UsesRs,
    input  logic              D_UsesRt,
    input  logic [REG_AW-1:0] E_Rd,
    input  logic              E_Wreg,
    input  logic              E_Reg2reg,
    input  logic [REG_AW-1:0] M_Rd,
    input  logic              M_Wreg,
    input  logic              Condep,
    input  logic              Mem_Busy,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              Stall,
    output logic              Bubble,
    output logic              Flush,
    output logic              Freeze,
    output logic [1:0]        Busy_St,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        FLUSH   = 2'b10,
        MEMWAIT = 2'b11
    } state_t;

    localparam logic [2:0] LOAD_INIT  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

    state_t     r_state, w_nextState;
    logic [2:0] r_cnt, w_nextCnt;
    logic       r_pendFlush, w_nextPend;
    logic       w_luh, w_branch;
    logic       w_exFwdA, w_memFwdA, w_exFwdB, w_memFwdB;

    // A load sitting in EX has no result yet, so it is never an EX forward source.
    assign w_exFwdA  = (D_Rs == E_Rd) && (E_Rd != '0) && E_Wreg && E_Reg2reg;
    assign w_memFwdA = (D_Rs == M_Rd) && (M_Rd != '0) && M_Wreg;
    assign w_exFwdB  = (D_Rt == E_Rd) && (E_Rd != '0) && E_Wreg && E_Reg2reg;
    assign w_memFwdB = (D_Rt == M_Rd) && (M_Rd != '0) && M_Wreg;

    assign FwdA = w_exFwdA ? 2'b10 : (w_memFwdA ? 2'b01 : 2'b00);
    assign FwdB = w_exFwdB ? 2'b10 : (w_memFwdB ? 2'b01 : 2'b00);

    assign w_luh = E_Wreg && !E_Reg2reg && (E_Rd != '0) &&
                   ((D_UsesRs && (D_Rs == E_Rd)) || (D_UsesRt && (D_Rt == E_Rd)));

    assign w_branch = Condep || r_pendFlush;
    assign Busy_St  = r_state;

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_pendFlush <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            r_pendFlush <= w_nextPend;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextPend  = r_pendFlush;
        Stall       = 1'b0;
        Bubble      = 1'b0;
        Flush       = 1'b0;
        Freeze      = 1'b0;
        unique case (r_state)
            RUN: begin
                // A branch that lands while memory is busy is parked and replayed once the freeze lifts.
                if (w_branch) begin
                    Flush      = 1'b1;
                    w_nextPend = 1'b0;
                    if (Mem_Busy) begin
                        Freeze      = 1'b1;
                        w_nextPend  = 1'b1;
                        w_nextState = MEMWAIT;
                    end else if (FLUSH_CYC > 1) begin
                        w_nextState = FLUSH;
                        w_nextCnt   = FLUSH_INIT;
                    end
                end else if (Mem_Busy) begin
                    Freeze      = 1'b1;
                    w_nextState = MEMWAIT;
                end else if (w_luh) begin
                    Stall  = 1'b1;
                    Bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_nextState = LDSTALL;
                        w_nextCnt   = LOAD_INIT;
                    end
                end
            end
            LDSTALL: begin
                Stall = 1'b1;
                if (Mem_Busy) begin
                    Freeze = 1'b1;
                end else begin
                    Bubble = 1'b1;
                    if (r_cnt == 3'd1) begin
                        w_nextState = RUN;
                        w_nextCnt   = '0;
                    end else begin
                        w_nextCnt = r_cnt - 3'd1;
                    end
                end
            end
            FLUSH: begin
                Flush = 1'b1;
                if (Mem_Busy) begin
                    Freeze = 1'b1;
                end else if (r_cnt == 3'd1) begin
                    w_nextState = RUN;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt - 3'd1;
                end
            end
            MEMWAIT: begin
                Freeze = 1'b1;
                if (!Mem_Busy) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = RUN;
                w_nextCnt   = '0;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stallCount, r_flushCount;

    // Saturating counters so a long run never wraps back to a misleading small value.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (Stall && (r_stallCount != 32'hFFFF_FFFF)) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
            if (Flush && (r_flushCount != 32'hFFFF_FFFF)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign StallCount = r_stallCount;
    assign FlushCount = r_flushCount;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: directed scenarios then random traffic, all checked against a cycle-count reference model.
module tb_hazard_fwd_ctrl;

    localparam int AW        = 5;
    localparam int LOAD_LAT  = 3;
    localparam int FLUSH_CYC = 2;

    logic          Clk = 1'b0;
    logic          Clrn;
    logic [AW-1:0] D_Rs, D_Rt, E_Rd, M_Rd;
    logic          D_UsesRs, D_UsesRt, E_Wreg, E_Reg2reg, M_Wreg, Condep, Mem_Busy;
    logic [1:0]    FwdA, FwdB, Busy_St;
    logic          Stall, Bubble, Flush, Freeze;
    logic [31:0]   StallCount, FlushCount;

    int passCount  = 0;
    int totalCount = 0;
    int failCount  = 0;

    // Reference model state expressed as remaining-cycle counts rather than FSM states.
    int mStallLeft = 0;
    int mFlushLeft = 0;
    bit mMemWait   = 0;
    bit mPend      = 0;
    int mStallCnt  = 0;
    int mFlushCnt  = 0;

    logic obsStall, obsBubble, obsFlush, obsFreeze;
    logic [1:0] obsFwdA, obsFwdB, obsSt;

    hazard_fwd_ctrl #(.REG_AW(AW), .LOAD_LAT(LOAD_LAT), .FLUSH_CYC(FLUSH_CYC)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UsesRs(D_UsesRs), .D_UsesRt(D_UsesRt),
        .E_Rd(E_Rd), .E_Wreg(E_Wreg), .E_Reg2reg(E_Reg2reg),
        .M_Rd(M_Rd), .M_Wreg(M_Wreg), .Condep(Condep), .Mem_Busy(Mem_Busy),
        .FwdA(FwdA), .FwdB(FwdB), .Stall(Stall), .Bubble(Bubble), .Flush(Flush),
        .Freeze(Freeze), .Busy_St(Busy_St), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount = totalCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [AW-1:0] src);
        if (src != 0 && src == E_Rd && E_Wreg && E_Reg2reg) return 2'b10;
        if (src != 0 && src == M_Rd && M_Wreg) return 2'b01;
        return 2'b00;
    endfunction

    task automatic applyStimulus(input logic [AW-1:0] dRs, input logic [AW-1:0] dRt,
                                 input logic uRs, input logic uRt,
                                 input logic [AW-1:0] eRd, input logic eW, input logic eR2r,
                                 input logic [AW-1:0] mRd, input logic mW,
                                 input logic cond, input logic busy, input logic clrn);
        logic eStall, eBubble, eFlush, eFreeze, luh;
        logic [1:0] eSt;
        @(negedge Clk);
        D_Rs = dRs; D_Rt = dRt; D_UsesRs = uRs; D_UsesRt = uRt;
        E_Rd = eRd; E_Wreg = eW; E_Reg2reg = eR2r; M_Rd = mRd; M_Wreg = mW;
        Condep = cond; Mem_Busy = busy; Clrn = clrn;
        #1;
        obsStall = Stall; obsBubble = Bubble; obsFlush = Flush; obsFreeze = Freeze;
        obsFwdA = FwdA; obsFwdB = FwdB; obsSt = Busy_St;
        if (!clrn) begin
            mStallLeft = 0; mFlushLeft = 0; mMemWait = 0; mPend = 0;
            mStallCnt = 0; mFlushCnt = 0;
        end else begin
            eStall = 0; eBubble = 0; eFlush = 0; eFreeze = 0;
            luh = eW && !eR2r && eRd != 0 && ((uRs && dRs == eRd) || (uRt && dRt == eRd));
            eSt = mMemWait ? 2'd3 : (mStallLeft > 0) ? 2'd1 : (mFlushLeft > 0) ? 2'd2 : 2'd0;
`ifdef HAZ_PERF_CNT_EN
            checkOutput("stallCount", StallCount, mStallCnt);
            checkOutput("flushCount", FlushCount, mFlushCnt);
`else
            checkOutput("stallCountOff", StallCount, 0);
            checkOutput("flushCountOff", FlushCount, 0);
`endif
            if (mMemWait) begin
                eFreeze = 1;
                if (!busy) mMemWait = 0;
            end else if (mStallLeft > 0) begin
                eStall = 1;
                if (busy) eFreeze = 1;
                else begin eBubble = 1; mStallLeft--; end
            end else if (mFlushLeft > 0) begin
                eFlush = 1;
                if (busy) eFreeze = 1;
                else mFlushLeft--;
            end else if (cond || mPend) begin
                eFlush = 1;
                mPend = 0;
                if (busy) begin eFreeze = 1; mMemWait = 1; mPend = 1; end
                else mFlushLeft = FLUSH_CYC - 1;
            end else if (busy) begin
                eFreeze = 1; mMemWait = 1;
            end else if (luh) begin
                eStall = 1; eBubble = 1; mStallLeft = LOAD_LAT - 1;
            end
            checkOutput("fwdA", obsFwdA, refFwd(dRs));
            checkOutput("fwdB", obsFwdB, refFwd(dRt));
            checkOutput("stall", obsStall, eStall);
            checkOutput("bubble", obsBubble, eBubble);
            checkOutput("flush", obsFlush, eFlush);
            checkOutput("freeze", obsFreeze, eFreeze);
            checkOutput("busySt", obsSt, eSt);
            mStallCnt += eStall;
            mFlushCnt += eFlush;
        end
        @(posedge Clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int stallSeen, freezeSeen, flushSeen, stallDuringFlush;

        // Reset with random inputs, then idle.
        repeat (2) applyStimulus(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                                 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                                 1'($urandom), 1'($urandom), 1'($urandom), 0);
        idle();
        checkOutput("rstState", obsSt, 2'b00);
        checkOutput("rstOuts", {obsStall, obsBubble, obsFlush, obsFreeze, obsFwdA, obsFwdB}, 0);

        // Forward priority.
        applyStimulus(3, 0, 1, 0, 3, 1, 1, 3, 1, 0, 0, 1);
        checkOutput("fwdExPrio", obsFwdA, 2'b10);
        applyStimulus(3, 0, 1, 0, 3, 0, 1, 3, 1, 0, 0, 1);
        checkOutput("fwdMem", obsFwdA, 2'b01);
        applyStimulus(0, 0, 1, 0, 0, 1, 1, 3, 1, 0, 0, 1);
        checkOutput("fwdR0", obsFwdA, 2'b00);

        // Load-use: three stall cycles, then MEM forwarding.
        idle();
        stallSeen = 0;
        applyStimulus(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 1);
        stallSeen += int'(obsStall & obsBubble);
        repeat (3) begin
            applyStimulus(0, 5, 0, 1, 0, 0, 1, 5, 1, 0, 0, 1);
            stallSeen += int'(obsStall & obsBubble);
        end
        checkOutput("ldStallCycles", stallSeen, 3);
        checkOutput("ldFwdB", obsFwdB, 2'b01);

        // Branch: two flush cycles with no stall.
        idle();
        flushSeen = 0; stallDuringFlush = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        flushSeen += int'(obsFlush); stallDuringFlush += int'(obsStall);
        repeat (2) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
            flushSeen += int'(obsFlush); stallDuringFlush += int'(obsStall);
        end
        checkOutput("brFlushCycles", flushSeen, 2);
        checkOutput("brNoStall", stallDuringFlush, 0);

        // Memory wait in the middle of a load-use stall.
        idle();
        applyStimulus(7, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1);
        freezeSeen = 0; stallSeen = 0;
        repeat (4) begin
            applyStimulus(7, 0, 1, 0, 0, 0, 1, 7, 1, 0, 1, 1);
            freezeSeen += int'(obsFreeze & obsStall & !obsBubble);
        end
        repeat (3) begin
            applyStimulus(7, 0, 1, 0, 0, 0, 1, 7, 1, 0, 0, 1);
            stallSeen += int'(obsStall & obsBubble);
        end
        checkOutput("mwFreezeCycles", freezeSeen, 4);
        checkOutput("mwRemainStall", stallSeen, 2);
        checkOutput("mwBackToRun", obsSt, 2'b00);

        // Branch coinciding with a busy memory: flush replayed after the freeze.
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1);
        checkOutput("coFlushFreeze", {obsFlush, obsFreeze}, 2'b11);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        checkOutput("coReplayFlush", {obsFlush, obsFreeze}, 2'b10);
        idle();
        idle();

        // Random traffic over a small register set to provoke matches.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 49) != 0));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
